puf_challenge_sequencer: RTL and testbench

//  Upstream driver and downstream collector for the arbiter PUF chain.
//  - Generates a sequence of challenges and pulses the chain Enable.
//  - Samples the arbiter Response and majority-votes repeated evaluations into one stable bit.
//  - Packs RESP_BITS voted bits into a response word, delivered over a valid/ready handshake.
//  - Counts non-unanimous bits as a reliability metric.

---
 rtl/puf_challenge_sequencer.sv | 155 +++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF sequencer: steps challenges, pulses Enable, majority-votes the
// synchronised response and packs voted bits into a word behind valid/ready.
module puf_challenge_sequencer #(
    parameter int  SIZE      = 8,
    parameter int  RESP_BITS = 16,
    parameter int  VOTES     = 5,
    parameter int  SETTLE    = 4,
    localparam int UW        = $clog2(RESP_BITS + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SIZE-1:0]      Seed,
    output logic                 Busy,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic [RESP_BITS-1:0] RespWord,
    output logic [UW-1:0]        UnstableBits,
    output logic                 PufEnable,
    output logic [SIZE-1:0]      PufChallenge,
    input  logic                 PufResponse
);
    localparam int CW = $clog2(SETTLE);
    localparam int VW = $clog2(VOTES + 1);
    localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t                 r_state, w_state_next;
    logic [1:0]             r_sync;
    logic [CW-1:0]          r_cnt;
    logic [VW-1:0]          r_vote;
    logic [VW-1:0]          r_ones;
    logic [KW-1:0]          r_k;
    logic [RESP_BITS-1:0]   r_shadow;
    logic [UW-1:0]          r_unst_shadow;
    logic [SIZE-1:0]        r_challenge;
    logic [RESP_BITS-1:0]   r_word;
    logic [UW-1:0]          r_unst;

    logic                   w_rsync;
    logic                   w_phase_end;
    logic [VW-1:0]          w_ones_final;
    logic [VW-1:0]          w_vote_final;
    logic                   w_votes_done;
    logic                   w_last_bit;
    logic                   w_bit;
    logic                   w_unstable;
    logic [RESP_BITS-1:0]   w_word_next;
    logic [UW-1:0]          w_unst_next;

    // The arbiter output is asynchronous to Clk, so it is sampled through two flops
    always_ff @(posedge Clk) begin
        if (Reset) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], PufResponse};
    end
    assign w_rsync = r_sync[1];

    assign w_phase_end  = (r_cnt == CW'(SETTLE - 1));
    assign w_ones_final = r_ones + VW'(w_rsync);
    assign w_vote_final = r_vote + VW'(1);
    assign w_votes_done = (w_vote_final == VW'(VOTES));
    assign w_last_bit   = (r_k == KW'(RESP_BITS - 1));
    assign w_bit        = (w_ones_final > VW'(VOTES / 2));
    assign w_unstable   = (w_ones_final != '0) && (w_ones_final != VW'(VOTES));
    assign w_unst_next  = r_unst_shadow + UW'(w_unstable);

    always_comb begin
        w_word_next      = r_shadow;
        w_word_next[r_k] = w_bit;
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (Start) w_state_next = S_LOW;
            S_LOW:  if (w_phase_end) w_state_next = S_HIGH;
            S_HIGH: begin
                if (w_phase_end) begin
                    if (w_votes_done && w_last_bit) w_state_next = S_DONE;
                    else                            w_state_next = S_LOW;
                end
            end
            S_DONE: if (RespReady) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (r_state == S_LOW) || (r_state == S_HIGH);
        PufEnable = (r_state == S_HIGH);
        RespValid = (r_state == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt         <= '0;
            r_vote        <= '0;
            r_ones        <= '0;
            r_k           <= '0;
            r_shadow      <= '0;
            r_unst_shadow <= '0;
            r_challenge   <= '0;
            r_word        <= '0;
            r_unst        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_challenge   <= Seed;
                        r_cnt         <= '0;
                        r_vote        <= '0;
                        r_ones        <= '0;
                        r_k           <= '0;
                        r_shadow      <= '0;
                        r_unst_shadow <= '0;
                    end
                end
                S_LOW: r_cnt <= w_phase_end ? '0 : r_cnt + CW'(1);
                S_HIGH: begin
                    r_cnt <= w_phase_end ? '0 : r_cnt + CW'(1);
                    if (w_phase_end) begin
                        if (!w_votes_done) begin
                            r_vote <= w_vote_final;
                            r_ones <= w_ones_final;
                        end else begin
                            r_shadow      <= w_word_next;
                            r_unst_shadow <= w_unst_next;
                            r_vote        <= '0;
                            r_ones        <= '0;
                            // Visible outputs only change once the whole word is in
                            if (!w_last_bit) begin
                                r_k         <= r_k + KW'(1);
                                r_challenge <= r_challenge + SIZE'(1);
                            end else begin
                                r_word <= w_word_next;
                                r_unst <= w_unst_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign PufChallenge = r_challenge;
    assign RespWord     = r_word;
    assign UnstableBits = r_unst;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with a behavioural arbiter model.
module tb_puf_challenge_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  Seed = 8'h00;
    logic        Busy;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [15:0] RespWord;
    logic [4:0]  UnstableBits;
    logic        PufEnable;
    logic [7:0]  PufChallenge;
    logic        PufResponse = 1'b0;

    int checks = 0;
    int errors = 0;

    // Arbiter model: 0 = constant, 1 = challenge LSB, 2 = n_ones of every 5 evaluations high
    int   mode = 0;
    logic resp_const = 1'b0;
    int   n_ones = 0;
    int   eval_cnt = 0;
    logic prev_en = 1'b0;

    puf_challenge_sequencer #(.SIZE(8), .RESP_BITS(16), .VOTES(5), .SETTLE(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Seed(Seed), .Busy(Busy),
        .RespValid(RespValid), .RespReady(RespReady), .RespWord(RespWord),
        .UnstableBits(UnstableBits), .PufEnable(PufEnable),
        .PufChallenge(PufChallenge), .PufResponse(PufResponse)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Busy) eval_cnt = 0;
        if (mode == 0) PufResponse = resp_const;
        else if (mode == 1) PufResponse = PufChallenge[0];
        else if (PufEnable && !prev_en) begin
            PufResponse = ((eval_cnt % 5) < n_ones);
            eval_cnt = eval_cnt + 1;
        end
        prev_en = PufEnable;
    end

    // Start accepted in cycle t; lat is the cycle offset where RespValid is first seen
    task automatic run_word(input logic [7:0] seed, output int lat);
        @(negedge Clk);
        Seed = seed;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 1;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", Busy);
        end
        while (!RespValid && lat < 2000) begin
            @(negedge Clk);
            lat++;
        end
        $display("word seed=%h lat=%0d word=%h unstable=%0d", seed, lat, RespWord, UnstableBits);
    endtask

    task automatic accept_word();
        RespReady = 1'b1;
        @(negedge Clk);
        RespReady = 1'b0;
        checks++;
        if (RespValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_accept: got %b want 0", RespValid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({RespValid, Busy, PufEnable} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {RespValid, Busy, PufEnable});
        end
        checks++;
        if (RespWord !== 16'h0000 || UnstableBits !== 5'd0) begin
            errors++;
            $display("FAIL reset_word: got %h/%0d want 0000/0", RespWord, UnstableBits);
        end
        checks++;
        if (PufChallenge !== 8'h00) begin
            errors++;
            $display("FAIL reset_challenge: got %h want 00", PufChallenge);
        end
        Reset = 1'b0;
    endtask

    task automatic test_const_one();
        int lat;
        mode = 0; resp_const = 1'b1;
        run_word(8'h00, lat);
        checks++;
        if (lat !== 641) begin
            errors++;
            $display("FAIL latency: got %0d want 641", lat);
        end
        checks++;
        if (RespWord !== 16'hFFFF || UnstableBits !== 5'd0) begin
            errors++;
            $display("FAIL const_one: got %h/%0d want FFFF/0", RespWord, UnstableBits);
        end
        accept_word();
        checks++;
        if (RespWord !== 16'hFFFF) begin
            errors++;
            $display("FAIL word_retained: got %h want FFFF", RespWord);
        end
    endtask

    task automatic test_parity();
        int lat;
        mode = 1;
        run_word(8'h00, lat);
        checks++;
        if (RespWord !== 16'hAAAA || UnstableBits !== 5'd0) begin
            errors++;
            $display("FAIL parity_00: got %h/%0d want AAAA/0", RespWord, UnstableBits);
        end
        accept_word();
        run_word(8'hFF, lat);
        checks++;
        if (RespWord !== 16'h5555 || UnstableBits !== 5'd0) begin
            errors++;
            $display("FAIL parity_wrap: got %h/%0d want 5555/0", RespWord, UnstableBits);
        end
        accept_word();
    endtask

    task automatic test_majority();
        int lat;
        mode = 2; n_ones = 3;
        run_word(8'h10, lat);
        checks++;
        if (RespWord !== 16'hFFFF || UnstableBits !== 5'd16) begin
            errors++;
            $display("FAIL vote_3of5: got %h/%0d want FFFF/16", RespWord, UnstableBits);
        end
        accept_word();
        n_ones = 2;
        run_word(8'h20, lat);
        checks++;
        if (RespWord !== 16'h0000 || UnstableBits !== 5'd16) begin
            errors++;
            $display("FAIL vote_2of5: got %h/%0d want 0000/16", RespWord, UnstableBits);
        end
        accept_word();
    endtask

    task automatic test_hold_done();
        int lat;
        mode = 1;
        run_word(8'h01, lat);
        for (int i = 0; i < 20; i++) begin
            Start = (i % 3 == 0);
            Seed = 8'h00;
            @(negedge Clk);
            checks++;
            if (RespWord !== 16'h5555 || RespValid !== 1'b1 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_done[%0d]: got %h v=%b b=%b want 5555 v=1 b=0",
                         i, RespWord, RespValid, Busy);
            end
        end
        Start = 1'b0;
        accept_word();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_accept: busy got %b want 0", Busy);
        end
    endtask

    task automatic test_ready_early();
        int lat;
        mode = 0; resp_const = 1'b0;
        RespReady = 1'b1;
        run_word(8'h33, lat);
        checks++;
        if (lat !== 641 || RespWord !== 16'h0000) begin
            errors++;
            $display("FAIL ready_early: got lat=%0d %h want 641 0000", lat, RespWord);
        end
        @(negedge Clk);
        RespReady = 1'b0;
        checks++;
        if (RespValid !== 1'b0) begin
            errors++;
            $display("FAIL ready_early_drop: got %b want 0", RespValid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        mode = 1;
        @(negedge Clk);
        Seed = 8'h00;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        // Cycle t+1+280+4 is the first HIGH cycle of bit 7
        repeat (285) @(negedge Clk);
        checks++;
        if (PufEnable !== 1'b1 || PufChallenge !== 8'h07) begin
            errors++;
            $display("FAIL mid_bit7: got en=%b ch=%h want en=1 ch=07", PufEnable, PufChallenge);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (PufEnable !== 1'b0 || Busy !== 1'b0 || RespValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got en=%b busy=%b v=%b want 000", PufEnable, Busy, RespValid);
        end
        run_word(8'h00, lat);
        checks++;
        if (lat !== 641 || RespWord !== 16'hAAAA || UnstableBits !== 5'd0) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d %h/%0d want 641 AAAA/0", lat, RespWord, UnstableBits);
        end
        accept_word();
    endtask

    initial begin
        test_reset();
        test_const_one();
        test_parity();
        test_majority();
        test_hold_done();
        test_ready_early();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
